// File: rtl/spi_pkg_reader_if.sv
// SPI link between the host-side package reader (master) and the DAQ slave.
interface spi_pkg_reader_if;
  logic cs_n;
  logic sck;
  logic miso;

  modport master (
    output cs_n,
    output sck,
    input  miso
  );

  modport slave (
    input  cs_n,
    input  sck,
    output miso
  );
endinterface

// File: rtl/spi_pkg_reader.sv
// SPI mode-0 master that drains one PACKAGE_SIZE-byte image package from the
// DAQ slave on every rising edge of its package-ready line, presenting each
// byte on a parallel bus with a one-cycle strobe.
module spi_pkg_reader #(
  parameter int PACKAGE_SIZE = 1000,
  parameter int SCK_DIV      = 2,
  parameter int CS_SETUP     = 2,
  parameter int CS_GAP       = 4
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              en,
  input  logic                              pkg_rdy,
  spi_pkg_reader_if.master                  spi,
  output logic [7:0]                        byte_out,
  output logic                              byte_valid,
  output logic                              pkg_done,
  output logic                              busy,
  output logic                              overrun,
  output logic [$clog2(PACKAGE_SIZE+1)-1:0] byte_cnt
);

  localparam int                CNT_W     = $clog2(PACKAGE_SIZE + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PACKAGE_SIZE);
  localparam logic [15:0]       SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0]       DIV_END   = 16'(SCK_DIV - 1);
  localparam logic [15:0]       GAP_END   = 16'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t           r_state;
  logic [2:0]       r_sync;
  logic [15:0]      r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_cs_n;
  logic             r_sck;
  logic [7:0]       r_byte_out;
  logic             r_byte_valid;
  logic             r_pkg_done;
  logic             r_busy;
  logic             r_overrun;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_pending;

  logic             w_trig;
  logic             w_pend;
  logic             w_gap_end;
  logic [7:0]       w_shift_in;

  // r_sync[1] is the synchronized level, r_sync[2] its one-cycle-old copy.
  assign w_trig     = en & r_sync[1] & ~r_sync[2];
  assign w_pend     = r_pending & en;
  assign w_gap_end  = (r_state == ST_GAP) && (r_cnt == GAP_END);
  assign w_shift_in = {r_shift[6:0], spi.miso};

  // Two-flop synchronizer for the asynchronous package-ready line plus edge-detect tap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], pkg_rdy};
    end
  end

  // Package sequencer: chip-select framing, sck generation, byte assembly, trigger queueing.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_pkg_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_byte_cnt   <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_pkg_done   <= 1'b0;
      r_overrun    <= 1'b0;

      // A trigger during a package queues one deep; a second one is dropped.
      // The last GAP cycle is excluded because there the trigger starts the
      // next package directly.
      if (w_trig && (r_state != ST_IDLE) && !w_gap_end) begin
        if (r_pending) begin
          r_overrun <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end
      if (!en) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trig || w_pend) begin
            r_state    <= ST_SETUP;
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_pending  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (r_cnt == SETUP_END) begin
            r_state <= ST_XFER;
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_XFER: begin
          if (r_cnt == DIV_END) begin
            r_cnt <= '0;
            if (!r_sck) begin
              // Rising sck: capture miso, which the slave set up after the last fall.
              r_sck   <= 1'b1;
              r_shift <= w_shift_in;
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_byte_out   <= w_shift_in;
                r_byte_valid <= 1'b1;
                r_byte_cnt   <= r_byte_cnt + 1'b1;
              end
            end else begin
              // Falling sck: after the last byte, stop here so no extra rise occurs.
              r_sck <= 1'b0;
              if (r_byte_cnt == LAST_CNT) begin
                r_state <= ST_HOLD;
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == DIV_END) begin
            r_cnt      <= '0;
            r_cs_n     <= 1'b1;
            r_pkg_done <= 1'b1;
            r_state    <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (w_gap_end) begin
            r_cnt <= '0;
            if (w_pend || w_trig) begin
              // Go straight back to SETUP so cs_n stays high exactly CS_GAP cycles.
              r_state    <= ST_SETUP;
              r_cs_n     <= 1'b0;
              r_byte_cnt <= '0;
              r_pending  <= w_pend & w_trig;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign spi.cs_n   = r_cs_n;
  assign spi.sck    = r_sck;
  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign pkg_done   = r_pkg_done;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_spi_pkg_reader.sv
// Bench for spi_pkg_reader: DUT A (SCK_DIV=2) and DUT B (SCK_DIV=1), each
// with a behavioural mode-0 slave and a byte scoreboard.
module tb_spi_pkg_reader;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic [31:0] data;     // four bytes the slave returns, first byte in [31:24]
    logic [7:0]  exp_cnt;  // byte_cnt expected after the package
    logic [7:0]  exp_lat;  // trigger to cs_n low, in cycles
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic en_a = 1'b1, rdy_a = 1'b0, en_b = 1'b1, rdy_b = 1'b0;
  logic [7:0] bo_a, bo_b;
  logic bv_a, bv_b, pd_a, pd_b, busy_a, busy_b, ov_a, ov_b;
  logic [CW-1:0] bc_a, bc_b;

  spi_pkg_reader_if if_a ();
  spi_pkg_reader_if if_b ();

  spi_pkg_reader #(.PACKAGE_SIZE(N), .SCK_DIV(2), .CS_SETUP(2), .CS_GAP(4)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en_a), .pkg_rdy(rdy_a), .spi(if_a.master),
    .byte_out(bo_a), .byte_valid(bv_a), .pkg_done(pd_a), .busy(busy_a), .overrun(ov_a),
    .byte_cnt(bc_a));

  spi_pkg_reader #(.PACKAGE_SIZE(N), .SCK_DIV(1), .CS_SETUP(2), .CS_GAP(4)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en_b), .pkg_rdy(rdy_b), .spi(if_b.master),
    .byte_out(bo_b), .byte_valid(bv_b), .pkg_done(pd_b), .busy(busy_b), .overrun(ov_b),
    .byte_cnt(bc_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Slave models: bit index counts sck falls since cs_n fell, MSB first.
  logic [31:0] sl_data_a = '0, sl_data_b = '0;
  int sl_bit_a = 0, sl_bit_b = 0;
  always @(negedge if_a.sck or posedge if_a.cs_n)
    if (if_a.cs_n) sl_bit_a = 0; else sl_bit_a = sl_bit_a + 1;
  always @(negedge if_b.sck or posedge if_b.cs_n)
    if (if_b.cs_n) sl_bit_b = 0; else sl_bit_b = sl_bit_b + 1;
  wire [31:0] sl_sh_a = sl_data_a << sl_bit_a;
  wire [31:0] sl_sh_b = sl_data_b << sl_bit_b;
  assign if_a.miso = sl_sh_a[31];
  assign if_b.miso = sl_sh_b[31];

  // Scoreboards and monitors.
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic gap_chk_a = 1'b0, skip_len_a = 1'b0;
  logic pcs_a = 1'b1, pcs_b = 1'b1;
  int t_fall_a = 0, t_rise_a = 0, t_bv_a = 0, idx_a = 0, pd_cnt_a = 0, ov_cnt_a = 0;
  int t_fall_b = 0, t_rise_b = 0, t_bv_b = 0, idx_b = 0, pd_cnt_b = 0;

  always @(negedge sys_clk) begin
    if (if_a.cs_n !== pcs_a) begin
      chk("a_sck_low_at_cs_edge", int'(if_a.sck), 0);
      if (!if_a.cs_n) begin
        if (gap_chk_a) chk("a_cs_gap_len", cyc - t_rise_a, 4);
        t_fall_a = cyc;
        idx_a    = 0;
      end else begin
        if (!skip_len_a) chk("a_cs_low_len", cyc - t_rise_a + t_rise_a - t_fall_a, 132);
        t_rise_a = cyc;
      end
      pcs_a = if_a.cs_n;
    end
    if (bv_a) begin
      idx_a++;
      $display("a byte %0d = %02h", idx_a, bo_a);
      chk("a_byte_cnt_at_valid", int'(bc_a), idx_a);
      if (idx_a > 1) chk("a_valid_spacing", cyc - t_bv_a, 32);
      t_bv_a = cyc;
      if (q_a.size() == 0) chk("a_unexpected_byte", int'(bo_a), -1);
      else chk("a_byte", int'(bo_a), int'(q_a.pop_front()));
    end
    if (pd_a) begin
      pd_cnt_a++;
      chk("a_done_with_cs_rise", int'(cyc == t_rise_a && if_a.cs_n), 1);
    end
    if (ov_a) ov_cnt_a++;
  end

  always @(negedge sys_clk) begin
    if (if_b.cs_n !== pcs_b) begin
      chk("b_sck_low_at_cs_edge", int'(if_b.sck), 0);
      if (!if_b.cs_n) begin
        t_fall_b = cyc;
        idx_b    = 0;
      end else begin
        chk("b_cs_low_len", cyc - t_fall_b, 67);
        t_rise_b = cyc;
      end
      pcs_b = if_b.cs_n;
    end
    if (bv_b) begin
      idx_b++;
      $display("b byte %0d = %02h", idx_b, bo_b);
      chk("b_byte_cnt_at_valid", int'(bc_b), idx_b);
      if (idx_b > 1) chk("b_valid_spacing", cyc - t_bv_b, 16);
      t_bv_b = cyc;
      if (q_b.size() == 0) chk("b_unexpected_byte", int'(bo_b), -1);
      else chk("b_byte", int'(bo_b), int'(q_b.pop_front()));
    end
    if (pd_b) begin
      pd_cnt_b++;
      chk("b_done_with_cs_rise", int'(cyc == t_rise_b && if_b.cs_n), 1);
    end
  end

  task automatic push_pkg(input bit sel, input logic [31:0] d);
    for (int b = 0; b < N; b++) begin
      if (sel) q_b.push_back(d[31-8*b -: 8]);
      else q_a.push_back(d[31-8*b -: 8]);
    end
  endtask

  task automatic pulse(input bit sel);
    @(negedge sys_clk);
    if (sel) rdy_b = 1'b1; else rdy_a = 1'b1;
    repeat (3) @(negedge sys_clk);
    if (sel) rdy_b = 1'b0; else rdy_a = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_pd(input bit sel, input int target);
    int n = 0;
    while (((sel ? pd_cnt_b : pd_cnt_a) < target) && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk(sel ? "b_pkg_done_count" : "a_pkg_done_count", sel ? pd_cnt_b : pd_cnt_a, target);
  endtask

  task automatic chk_reset_a();
    chk("a_rst_cs_n", int'(if_a.cs_n), 1);
    chk("a_rst_sck", int'(if_a.sck), 0);
    chk("a_rst_byte_out", int'(bo_a), 0);
    chk("a_rst_byte_valid", int'(bv_a), 0);
    chk("a_rst_pkg_done", int'(pd_a), 0);
    chk("a_rst_busy", int'(busy_a), 0);
    chk("a_rst_overrun", int'(ov_a), 0);
    chk("a_rst_byte_cnt", int'(bc_a), 0);
  endtask

  initial begin
    vec_t vecs[4];
    int lat, pd_exp, ov0, n, seen_low, seen_busy;
    vecs[0] = '{data: 32'hA53C_FF01, exp_cnt: 8'd4, exp_lat: 8'd3};
    vecs[1] = '{data: 32'h8000_0000, exp_cnt: 8'd4, exp_lat: 8'd3};
    vecs[2] = '{data: 32'h00FF_55AA, exp_cnt: 8'd4, exp_lat: 8'd3};
    vecs[3] = '{data: $urandom(),    exp_cnt: 8'd4, exp_lat: 8'd3};
    pd_exp = 0;

    repeat (3) @(negedge sys_clk);
    chk_reset_a();
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Table-driven single packages.
    for (int i = 0; i < 4; i++) begin
      sl_data_a = vecs[i].data;
      push_pkg(1'b0, vecs[i].data);
      @(negedge sys_clk);
      rdy_a = 1'b1;
      lat = 0;
      do begin
        @(negedge sys_clk);
        lat++;
      end while (if_a.cs_n && lat < 10);
      chk("a_trigger_latency", lat, int'(vecs[i].exp_lat));
      chk("a_busy_on_start", int'(busy_a), 1);
      pd_exp++;
      wait_pd(1'b0, pd_exp);
      rdy_a = 1'b0;
      repeat (6) @(negedge sys_clk);
      chk("a_byte_cnt_hold", int'(bc_a), int'(vecs[i].exp_cnt));
      chk("a_queue_drained", q_a.size(), 0);
      chk("a_busy_off_after_gap", int'(busy_a), 0);
    end

    // Back-to-back: second edge queues, third edge overruns once.
    sl_data_a = 32'h1234_5678;
    push_pkg(1'b0, sl_data_a);
    push_pkg(1'b0, sl_data_a);
    ov0 = ov_cnt_a;
    pulse(1'b0);
    gap_chk_a = 1'b1;
    repeat (40) @(negedge sys_clk);
    pulse(1'b0);
    chk("a_no_overrun_first_pending", ov_cnt_a - ov0, 0);
    repeat (20) @(negedge sys_clk);
    pulse(1'b0);
    pd_exp += 2;
    wait_pd(1'b0, pd_exp);
    gap_chk_a = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("a_b2b_overrun_count", ov_cnt_a - ov0, 1);
    chk("a_b2b_queue_drained", q_a.size(), 0);
    chk("a_b2b_idle_after", int'(busy_a), 0);

    // Enable gating while idle.
    en_a = 1'b0;
    pulse(1'b0);
    seen_low = 0;
    seen_busy = 0;
    repeat (12) begin
      @(negedge sys_clk);
      if (!if_a.cs_n) seen_low = 1;
      if (busy_a) seen_busy = 1;
    end
    chk("a_en_gate_cs_low_seen", seen_low, 0);
    chk("a_en_gate_busy_seen", seen_busy, 0);
    en_a = 1'b1;

    // Drop en mid-package: the package completes, the pending trigger is discarded.
    sl_data_a = 32'h5AC3_0F96;
    push_pkg(1'b0, sl_data_a);
    pulse(1'b0);
    repeat (20) @(negedge sys_clk);
    pulse(1'b0);
    repeat (10) @(negedge sys_clk);
    en_a = 1'b0;
    pd_exp++;
    wait_pd(1'b0, pd_exp);
    repeat (30) @(negedge sys_clk);
    chk("a_en_drop_no_extra_pkg", pd_cnt_a, pd_exp);
    chk("a_en_drop_byte_cnt", int'(bc_a), 4);
    chk("a_en_drop_queue", q_a.size(), 0);
    en_a = 1'b1;

    // Reset after byte 2.
    sl_data_a = 32'hC001_D00D;
    push_pkg(1'b0, sl_data_a);
    skip_len_a = 1'b1;
    pulse(1'b0);
    n = 0;
    while (bc_a < CW'(2) && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    chk("a_reached_byte2", int'(bc_a), 2);
    #2 sys_rst_n = 1'b0;
    #1 chk_reset_a();
    q_a.delete();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("a_no_done_after_reset", pd_cnt_a, pd_exp);
    skip_len_a = 1'b0;
    sl_data_a = 32'h0102_0408;
    push_pkg(1'b0, sl_data_a);
    pulse(1'b0);
    pd_exp++;
    wait_pd(1'b0, pd_exp);
    repeat (6) @(negedge sys_clk);
    chk("a_post_reset_byte_cnt", int'(bc_a), 4);
    chk("a_post_reset_queue", q_a.size(), 0);

    // SCK_DIV=1 corner on DUT B.
    sl_data_b = 32'hE7_0F_5A_C3;
    push_pkg(1'b1, sl_data_b);
    pulse(1'b1);
    wait_pd(1'b1, 1);
    repeat (6) @(negedge sys_clk);
    chk("b_byte_cnt", int'(bc_b), 4);
    chk("b_queue_drained", q_b.size(), 0);
    chk("b_busy_off", int'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
